// File: rtl/usb_inject_sched_pkg.sv
// Shared types for the USB proxy injection scheduler: PID codes, proxy decoder
// states, scheduler FSM states and the statistics counter width.
// Latency: n/a (types only). Backpressure: n/a.
package usb_inject_sched_pkg;

   // Full PID byte as decoded by the proxy (PID nibble plus its complement).
   typedef enum logic [7:0] {
      OUT_Token   = 8'hE1,
      IN_Token    = 8'h69,
      SOF_Token   = 8'hA5,
      SETUP_Token = 8'h2D,
      DATA0       = 8'hC3,
      DATA1       = 8'h4B,
      ACK         = 8'hD2,
      NAK         = 8'h5A,
      STALL       = 8'h1E
   } pid_e;

   // Proxy decoder state encoding.
   typedef enum logic [2:0] {
      US_IDLE = 3'd0,
      US_SYNC = 3'd1,
      US_PID  = 3'd2,
      US_DATA = 3'd3,
      US_EOP  = 3'd4
   } usb_state_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARB,
      S_OWN,
      S_RELEASE
   } inj_state_e;

   localparam int STAT_W = 16;

endpackage

// File: rtl/usb_inject_sched_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i (mod N).
// Latency: purely combinational. Backpressure: none; the caller decides when to use the result.
// Ports: req_i (N requests), ptr_i (start index) -> gnt_o (one-hot), idx_o (index), vld_o (any request).
module usb_inject_sched_rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          vld_o
);

   int j;

   // Scan from the farthest position back to ptr_i so the closest hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      j     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = PW'(j);
            vld_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_inject_sched.sv
// Waits for a bus-idle gap, grants one requester round-robin and owns the USB proxy for one packet.
// Latency: idle gap met in cycle N -> grant pulse in N+1 -> owned registered from N+2.
// Backpressure: requests are levels; they wait until the gap, IN-token and proxy_en conditions allow.
// Ports: clk_i, rst_i (async, active-high), proxy_en_i, usb_state_i, pid_i, req_i, req_data_i ->
//        grant_o, done_o, owned_o, own_data_o, busy_o, timeout_o.
// Optional: define USB_INJ_STATS_EN to add saturating stat_grants_o / stat_timeouts_o counters.
module usb_inject_sched
   import usb_inject_sched_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int GAP_CYCLES = 32,
   parameter int MAX_OWN    = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 proxy_en_i,
   input  logic [2:0]           usb_state_i,
   input  logic [7:0]           pid_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*64-1:0]   req_data_i,
   output logic [NREQ-1:0]      grant_o,
   output logic [NREQ-1:0]      done_o,
   output logic                 owned_o,
   output logic [63:0]          own_data_o,
   output logic                 busy_o,
   output logic                 timeout_o
`ifdef USB_INJ_STATS_EN
   ,
   output logic [NREQ*16-1:0]   stat_grants_o,
   output logic [15:0]          stat_timeouts_o
`endif
);

   localparam int PW = $clog2(NREQ);
   localparam int IW = $clog2(GAP_CYCLES + 1);
   localparam int OW = $clog2(MAX_OWN);

   inj_state_e       state_q;
   logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
   logic [PW-1:0]    rr_ptr_q;
   logic [PW-1:0]    idx_q;
   logic [OW-1:0]    own_cnt_q;
   logic             seen_active_q;
   logic             owned_q;
   logic [63:0]      own_data_q;
   logic [NREQ-1:0]  done_q;
   logic             timeout_q;

   logic [NREQ-1:0]  arb_gnt;
   logic [PW-1:0]    arb_idx;
   logic             arb_vld;
   logic [63:0]      sel_data;
   logic             bus_idle;
   logic             gap_met;

   usb_inject_sched_rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
      .req_i (req_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   assign bus_idle = (usb_state_i == US_IDLE);
   assign gap_met  = (idle_cnt_q == IW'(GAP_CYCLES));

   // Gap counter restarts on any bus activity and after every owned packet.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (!bus_idle || state_q == S_RELEASE) idle_cnt_d = '0;
      else if (!gap_met)                     idle_cnt_d = idle_cnt_q + 1'b1;
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_idx == PW'(i)) sel_data = req_data_i[64*i +: 64];
      end
   end

   // Grant is decided in the arbitration cycle itself, so it is decoded from the state register.
   assign grant_o    = (state_q == S_ARB && proxy_en_i) ? arb_gnt : '0;
   assign done_o     = done_q;
   assign timeout_o  = timeout_q;
   assign owned_o    = owned_q;
   assign own_data_o = own_data_q;
   assign busy_o     = (state_q != S_IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         idle_cnt_q    <= '0;
         rr_ptr_q      <= '0;
         idx_q         <= '0;
         own_cnt_q     <= '0;
         seen_active_q <= 1'b0;
         owned_q       <= 1'b0;
         own_data_q    <= '0;
         done_q        <= '0;
         timeout_q     <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         done_q     <= '0;
         timeout_q  <= 1'b0;
         if (!proxy_en_i) begin
            // Abort silently; a grant already pulsed stays issued.
            state_q <= S_IDLE;
            owned_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  // After an IN token the device owns the next slot.
                  if (|req_i && gap_met && pid_i != IN_Token) state_q <= S_ARB;
               end
               S_ARB: begin
                  if (arb_vld) begin
                     own_data_q    <= sel_data;
                     idx_q         <= arb_idx;
                     rr_ptr_q      <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                     own_cnt_q     <= '0;
                     seen_active_q <= 1'b0;
                     owned_q       <= 1'b1;
                     state_q       <= S_OWN;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               S_OWN: begin
                  own_cnt_q <= own_cnt_q + 1'b1;
                  if (!bus_idle) seen_active_q <= 1'b1;
                  // Normal completion has priority over the watchdog.
                  if (seen_active_q && bus_idle) begin
                     done_q  <= {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
                     owned_q <= 1'b0;
                     state_q <= S_RELEASE;
                  end else if (own_cnt_q == OW'(MAX_OWN - 1)) begin
                     timeout_q <= 1'b1;
                     owned_q   <= 1'b0;
                     state_q   <= S_RELEASE;
                  end
               end
               S_RELEASE: state_q <= S_IDLE;
               default:   state_q <= S_IDLE;
            endcase
         end
      end
   end

`ifdef USB_INJ_STATS_EN
   logic [NREQ-1:0][STAT_W-1:0] stat_grants_q;
   logic [STAT_W-1:0]           stat_timeouts_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_grants_q   <= '0;
         stat_timeouts_q <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant_o[i] && stat_grants_q[i] != '1) stat_grants_q[i] <= stat_grants_q[i] + 1'b1;
         end
         if (timeout_q && stat_timeouts_q != '1) stat_timeouts_q <= stat_timeouts_q + 1'b1;
      end
   end

   assign stat_grants_o   = stat_grants_q;
   assign stat_timeouts_o = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_usb_inject_sched.sv
// Directed bench for usb_inject_sched: inputs driven and outputs sampled on the falling clock edge.
// Latency: n/a. Backpressure: n/a.
module tb_usb_inject_sched;

   localparam int NREQ = 4;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                proxy_en_i;
   logic [2:0]          usb_state_i;
   logic [7:0]          pid_i;
   logic [NREQ-1:0]     req_i;
   logic [NREQ*64-1:0]  req_data_i;
   logic [NREQ-1:0]     grant_o;
   logic [NREQ-1:0]     done_o;
   logic                owned_o;
   logic [63:0]         own_data_o;
   logic                busy_o;
   logic                timeout_o;
`ifdef USB_INJ_STATS_EN
   logic [NREQ*16-1:0]  stat_grants_o;
   logic [15:0]         stat_timeouts_o;
`endif

   always #5 clk_i = ~clk_i;

   usb_inject_sched #(.NREQ(NREQ), .GAP_CYCLES(32), .MAX_OWN(4096)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .proxy_en_i      (proxy_en_i),
      .usb_state_i     (usb_state_i),
      .pid_i           (pid_i),
      .req_i           (req_i),
      .req_data_i      (req_data_i),
      .grant_o         (grant_o),
      .done_o          (done_o),
      .owned_o         (owned_o),
      .own_data_o      (own_data_o),
      .busy_o          (busy_o),
      .timeout_o       (timeout_o)
`ifdef USB_INJ_STATS_EN
      ,
      .stat_grants_o   (stat_grants_o),
      .stat_timeouts_o (stat_timeouts_o)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] payload(input int i);
      logic [63:0] p;
      p = 64'hDEAD_BEEF_0000_0000 | 64'(i * 17 + 3);
      return p;
   endfunction

   task automatic nclk(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // Bounded wait for a grant pulse; n = falling edges consumed, g = grant seen (0 if none).
   task automatic wait_grant(input int max, output int n, output logic [NREQ-1:0] g);
      n = 0;
      g = '0;
      while (n < max) begin
         @(negedge clk_i);
         n++;
         if (grant_o != '0) begin
            g = grant_o;
            break;
         end
      end
   endtask

   // Bus activity 1 -> 3 -> 4 -> 0; returns on the edge where done should be visible.
   task automatic packet();
      usb_state_i = 3'd1; nclk(1);
      usb_state_i = 3'd3; nclk(1);
      usb_state_i = 3'd4; nclk(1);
      usb_state_i = 3'd0; nclk(1);
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      nclk(1);
      rst_i = 1'b0;
   endtask

   initial begin
      int               n;
      logic [NREQ-1:0]  g;
      logic             dropped;
      logic [NREQ-1:0]  exp_g;

      rst_i       = 1'b1;
      proxy_en_i  = 1'b1;
      usb_state_i = 3'd0;
      pid_i       = 8'hD2;
      req_i       = '0;
      for (int i = 0; i < NREQ; i++) req_data_i[64*i +: 64] = payload(i);
      nclk(2);

      chk("rst_grant",    64'(grant_o),    64'd0);
      chk("rst_done",     64'(done_o),     64'd0);
      chk("rst_owned",    64'(owned_o),    64'd0);
      chk("rst_own_data", own_data_o,      64'd0);
      chk("rst_busy",     64'(busy_o),     64'd0);
      chk("rst_timeout",  64'(timeout_o),  64'd0);
      rst_i = 1'b0;

      // Single requester after a long idle stretch.
      nclk(40);
      chk("t1_no_req_grant", 64'(grant_o), 64'd0);
      chk("t1_no_req_busy",  64'(busy_o),  64'd0);
      req_i = 4'b0100;
      nclk(1);
      chk("t1_grant",      64'(grant_o), 64'h4);
      chk("t1_arb_busy",   64'(busy_o),  64'd1);
      chk("t1_arb_owned",  64'(owned_o), 64'd0);
      nclk(1);
      chk("t1_owned",      64'(owned_o), 64'd1);
      chk("t1_own_data",   own_data_o,   payload(2));
      chk("t1_grant_once", 64'(grant_o), 64'd0);
      req_i = '0;
      packet();
      chk("t1_done",       64'(done_o),  64'h4);
      chk("t1_rel_owned",  64'(owned_o), 64'd0);
      nclk(1);
      chk("t1_done_once",  64'(done_o),  64'd0);

      // Round-robin over all four with each packet completing.
      pulse_reset();
      req_i = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(60, n, g);
         exp_g = 4'b0001 << (k % 4);
         chk($sformatf("t2_gap%0d", k),   64'(n), (k == 0) ? 64'd33 : 64'd34);
         chk($sformatf("t2_grant%0d", k), 64'(g), 64'(exp_g));
         nclk(1);
         chk($sformatf("t2_data%0d", k),  own_data_o, payload(k % 4));
         packet();
         chk($sformatf("t2_done%0d", k),  64'(done_o), 64'(exp_g));
      end
      req_i = '0;

      // IN token blocks injection; gap restarts after the data packet.
      pulse_reset();
      pid_i = 8'h69;
      req_i = 4'b0001;
      wait_grant(100, n, g);
      chk("t3_in_block", 64'(g), 64'd0);
      usb_state_i = 3'd3;
      nclk(1);
      pid_i       = 8'h4B;
      usb_state_i = 3'd0;
      wait_grant(60, n, g);
      chk("t3_gap",   64'(n), 64'd33);
      chk("t3_grant", 64'(g), 64'h1);

      // Watchdog with the bus stuck idle.
      nclk(1);
      chk("t4_owned", 64'(owned_o), 64'd1);
      chk("t4_data",  own_data_o,   payload(0));
      n = 1;
      dropped = 1'b0;
      while (n < 5000 && !timeout_o) begin
         if (!owned_o) dropped = 1'b1;
         nclk(1);
         n++;
      end
      chk("t4_timeout_at", 64'(n),         64'd4097);
      chk("t4_held",       64'(dropped),   64'd0);
      chk("t4_timeout",    64'(timeout_o), 64'd1);
      chk("t4_owned_off",  64'(owned_o),   64'd0);
      chk("t4_no_done",    64'(done_o),    64'd0);
      nclk(1);
      chk("t4_pulse",      64'(timeout_o), 64'd0);
      chk("t4_idle",       64'(busy_o),    64'd0);

      // Activity arrives exactly when the gap would have completed.
      pid_i = 8'hD2;
      req_i = 4'b0001;
      pulse_reset();
      wait_grant(31, n, g);
      chk("t6_early", 64'(g), 64'd0);
      usb_state_i = 3'd1;
      nclk(1);
      chk("t6_edge_grant", 64'(grant_o), 64'd0);
      chk("t6_edge_busy",  64'(busy_o),  64'd0);
      usb_state_i = 3'd0;
      wait_grant(60, n, g);
      chk("t6_restart", 64'(n), 64'd33);
      chk("t6_grant",   64'(g), 64'h1);

      // proxy_en drop aborts ownership without done.
      nclk(1);
      chk("t5_owned", 64'(owned_o), 64'd1);
      usb_state_i = 3'd1;
      nclk(1);
      proxy_en_i  = 1'b0;
      usb_state_i = 3'd0;
      nclk(1);
      chk("t5_en_owned",   64'(owned_o),   64'd0);
      chk("t5_en_done",    64'(done_o),    64'd0);
      chk("t5_en_busy",    64'(busy_o),    64'd0);
      chk("t5_en_timeout", 64'(timeout_o), 64'd0);
      proxy_en_i = 1'b1;

      // Asynchronous reset in the middle of an owned packet.
      wait_grant(100, n, g);
      chk("t5_regrant", 64'(g), 64'h1);
      nclk(1);
      chk("t5_owned2", 64'(owned_o), 64'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("t5_rst_owned", 64'(owned_o),   64'd0);
      chk("t5_rst_busy",  64'(busy_o),    64'd0);
      chk("t5_rst_data",  own_data_o,     64'd0);
      chk("t5_rst_grant", 64'(grant_o),   64'd0);
      chk("t5_rst_done",  64'(done_o),    64'd0);
      nclk(1);
      rst_i = 1'b0;
      nclk(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
